// File: rtl/idli_wr_arb_m.sv
// rtl/idli_wr_arb_m.sv - register-file write port arbiter, EX vs LD, four nibble-serial cycles per write
module idli_wr_arb_m (
  input  logic       i_wa_gck,
  input  logic       i_wa_rst_n,
  input  logic       i_wa_ex_vld,
  input  logic [3:0] i_wa_ex_reg,
  input  logic [3:0] i_wa_ex_data,
  output logic       o_wa_ex_gnt,
  input  logic       i_wa_ld_vld,
  input  logic [3:0] i_wa_ld_reg,
  input  logic [3:0] i_wa_ld_data,
  output logic       o_wa_ld_gnt,
  output logic       o_wa_wen,
  output logic [3:0] o_wa_reg,
  output logic [1:0] o_wa_nib,
  output logic [3:0] o_wa_data,
  output logic       o_wa_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Owner / last-winner encoding: 0 = EX, 1 = LD.
  localparam logic SRC_EX = 1'b0;
  localparam logic SRC_LD = 1'b1;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic [3:0] reg_q, reg_d;
  logic       last_q, last_d;

  logic       busy;
  logic       arb_pt;
  logic       ex_gnt;
  logic       ld_gnt;

  assign busy = (state_q == ST_BUSY);

  // Grant decision: a new write may start when idle or on the last nibble of
  // the current one; on contention the requester that did not win last time goes.
  always_comb begin
    arb_pt = 1'b0;
    ex_gnt = 1'b0;
    ld_gnt = 1'b0;
    arb_pt = !busy || (cnt_q == 2'd3);
    ex_gnt = arb_pt && i_wa_ex_vld && (!i_wa_ld_vld || (last_q == SRC_LD));
    ld_gnt = arb_pt && i_wa_ld_vld && (!i_wa_ex_vld || (last_q == SRC_EX));
  end

  // Next state: a grant (re)starts a write at nibble 0, otherwise step through
  // the nibbles and drop back to idle after nibble 3.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    reg_d   = reg_q;
    last_d  = last_q;
    if (ex_gnt || ld_gnt) begin
      state_d = ST_BUSY;
      cnt_d   = 2'd0;
      owner_d = ld_gnt ? SRC_LD : SRC_EX;
      last_d  = ld_gnt ? SRC_LD : SRC_EX;
      reg_d   = ld_gnt ? i_wa_ld_reg : i_wa_ex_reg;
    end else if (busy) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State register; reset aborts any write in flight and biases the first
  // contended arbitration towards EX by recording LD as the last winner.
  always_ff @(posedge i_wa_gck or negedge i_wa_rst_n) begin
    if (!i_wa_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      owner_q <= SRC_EX;
      reg_q   <= 4'd0;
      last_q  <= SRC_LD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      reg_q   <= reg_d;
      last_q  <= last_d;
    end
  end

  // Write port: data comes straight from the owner's input with no added
  // latency; index and data are forced to zero while idle.
  always_comb begin
    o_wa_ex_gnt = ex_gnt;
    o_wa_ld_gnt = ld_gnt;
    o_wa_wen    = busy;
    o_wa_busy   = busy;
    o_wa_nib    = cnt_q;
    o_wa_reg    = 4'd0;
    o_wa_data   = 4'd0;
    if (busy) begin
      o_wa_reg  = reg_q;
      o_wa_data = (owner_q == SRC_LD) ? i_wa_ld_data : i_wa_ex_data;
    end
  end

endmodule

// File: tb/tb_idli_wr_arb_m.sv
// tb/tb_idli_wr_arb_m.sv - directed self-checking bench for idli_wr_arb_m
module tb_idli_wr_arb_m;

  logic       clk;
  logic       rst_n;
  logic       ex_vld;
  logic [3:0] ex_reg;
  logic [3:0] ex_data;
  logic       ex_gnt;
  logic       ld_vld;
  logic [3:0] ld_reg;
  logic [3:0] ld_data;
  logic       ld_gnt;
  logic       wen;
  logic [3:0] wreg;
  logic [1:0] nib;
  logic [3:0] wdata;
  logic       busy;

  int n_checks;
  int n_errors;

  idli_wr_arb_m dut (
    .i_wa_gck     (clk),
    .i_wa_rst_n   (rst_n),
    .i_wa_ex_vld  (ex_vld),
    .i_wa_ex_reg  (ex_reg),
    .i_wa_ex_data (ex_data),
    .o_wa_ex_gnt  (ex_gnt),
    .i_wa_ld_vld  (ld_vld),
    .i_wa_ld_reg  (ld_reg),
    .i_wa_ld_data (ld_data),
    .o_wa_ld_gnt  (ld_gnt),
    .o_wa_wen     (wen),
    .o_wa_reg     (wreg),
    .o_wa_nib     (nib),
    .o_wa_data    (wdata),
    .o_wa_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wen"},  {31'd0, wen},  32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_reg"},  {28'd0, wreg}, 32'd0);
    chk({tag, "_data"}, {28'd0, wdata}, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] en, input logic [3:0] er, input logic [3:0] ed);
    chk({tag, "_wen"},  {31'd0, wen},   32'd1);
    chk({tag, "_busy"}, {31'd0, busy},  32'd1);
    chk({tag, "_nib"},  {30'd0, nib},   {30'd0, en});
    chk({tag, "_reg"},  {28'd0, wreg},  {28'd0, er});
    chk({tag, "_data"}, {28'd0, wdata}, {28'd0, ed});
  endtask

  task automatic chk_gnt(input string tag, input logic eg, input logic lg);
    chk({tag, "_exgnt"}, {31'd0, ex_gnt}, {31'd0, eg});
    chk({tag, "_ldgnt"}, {31'd0, ld_gnt}, {31'd0, lg});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n   = 1'b0;
    ex_vld  = 1'b0;
    ex_reg  = 4'd0;
    ex_data = 4'd0;
    ld_vld  = 1'b0;
    ld_reg  = 4'd0;
    ld_data = 4'd0;
    #2;
    chk_idle("rst");
    chk("rst_nib", {30'd0, nib}, 32'd0);
    chk_gnt("rst", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // Contention straight after reset: EX first, LD back-to-back at nibble 3
    ex_vld = 1'b1; ex_reg = 4'd3;
    ld_vld = 1'b1; ld_reg = 4'd9;
    #1;
    chk_gnt("c21_arb", 1'b1, 1'b0);
    chk_idle("c21_pre");
    for (int k = 0; k < 4; k++) begin
      step();
      ex_vld = 1'b0;
      ex_data = 4'(k + 8);
      #1;
      chk_wr("c21_ex", 2'(k), 4'd3, 4'(k + 8));
      chk_gnt("c21_ex", 1'b0, (k == 3));
    end
    for (int k = 0; k < 4; k++) begin
      step();
      ld_vld = 1'b0;
      ld_data = 4'(k + 12);
      #1;
      chk_wr("c21_ld", 2'(k), 4'd9, 4'(k + 12));
      chk_gnt("c21_ld", 1'b0, 1'b0);
    end
    step();
    #1;
    chk_idle("c21_end");

    // Persistent contention over four writes: EX, LD, EX, LD with no gap
    for (int t = 0; t <= 17; t++) begin
      logic ld_own;
      if (t > 0) step();
      ex_vld  = (t <= 12);
      ld_vld  = (t <= 12);
      ex_reg  = 4'h6;
      ld_reg  = 4'hA;
      ex_data = 4'(t);
      ld_data = ~4'(t);
      #1;
      chk_gnt("c22", (t == 0 || t == 8), (t == 4 || t == 12));
      if (t == 0 || t == 17) begin
        chk_idle("c22_idle");
      end else begin
        ld_own = (((t - 1) / 4) % 2) == 1;
        chk_wr("c22_wr", 2'((t - 1) % 4), ld_own ? 4'hA : 4'h6, ld_own ? ~4'(t) : 4'(t));
      end
    end

    // EX only: nibbles 1..4 to register 5, then idle
    step();
    ex_vld = 1'b1; ex_reg = 4'd5;
    #1;
    chk_gnt("c20_arb", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      ex_vld = 1'b0;
      ex_data = 4'(k + 1);
      #1;
      chk_wr("c20", 2'(k), 4'd5, 4'(k + 1));
      chk_gnt("c20", 1'b0, 1'b0);
    end
    step();
    #1;
    chk_idle("c20_end");

    // EX again (same requester back-to-back); LD asks at nibble 1 and waits to nibble 3
    ex_vld = 1'b1; ex_reg = 4'd2;
    #1;
    chk_gnt("c23_arb", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      ex_vld = 1'b0;
      ex_data = 4'(k + 1);
      ld_vld = (k >= 1);
      ld_reg = 4'hD;
      #1;
      chk_wr("c23_ex", 2'(k), 4'd2, 4'(k + 1));
      chk_gnt("c23_ex", 1'b0, (k == 3));
    end
    // LD owns; EX toggles its data and reg every cycle
    for (int k = 0; k < 4; k++) begin
      step();
      ld_vld  = 1'b0;
      ld_data = 4'(k + 5);
      ex_reg  = (k % 2 == 0) ? 4'hF : 4'h0;
      ex_data = ~4'(k + 5);
      #1;
      chk_wr("c25_ld", 2'(k), 4'hD, 4'(k + 5));
      chk_gnt("c25_ld", 1'b0, 1'b0);
    end
    step();
    ex_reg = 4'd0; ex_data = 4'd0;
    #1;
    chk_idle("c25_end");

    // Reset at nibble 2 aborts the write; contention afterwards goes to EX
    ex_vld = 1'b1; ex_reg = 4'd7;
    #1;
    chk_gnt("c24_arb", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      ex_vld = 1'b0;
      ex_data = 4'(k + 2);
      #1;
      chk_wr("c24_pre", 2'(k), 4'd7, 4'(k + 2));
    end
    rst_n = 1'b0;
    #1;
    chk_idle("c24_rst");
    chk("c24_rst_nib", {30'd0, nib}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk_idle("c24_rel0");
    step();
    #1;
    chk_idle("c24_rel1");
    step();
    ex_vld = 1'b1; ex_reg = 4'd1;
    ld_vld = 1'b1; ld_reg = 4'd2;
    #1;
    chk_gnt("c24_arb2", 1'b1, 1'b0);
    step();
    ex_vld = 1'b0; ld_vld = 1'b0;
    ex_data = 4'd3;
    #1;
    chk_wr("c24_new", 2'd0, 4'd1, 4'd3);
    repeat (4) step();
    #1;
    chk_idle("c24_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idli_wr_arb_m.md
IDLI_WR_ARB_M -- requirements
Module: idli_wr_arb_m

Interface
REQ-001 The block SHALL expose the following ports, one per line: name  direction  width  meaning.
- i_wa_gck  in  1  gated clock; all state updates on its rising edge.
- i_wa_rst_n  in  1  asynchronous active-low reset.
- i_wa_ex_vld  in  1  execution unit requests one register write.
- i_wa_ex_reg  in  4  destination register of the execution unit write.
- i_wa_ex_data  in  4  execution unit write-data nibble for the current phase.
- o_wa_ex_gnt  out  1  execution unit request accepted this cycle.
- i_wa_ld_vld  in  1  load unit requests one register write.
- i_wa_ld_reg  in  4  destination register of the load unit write.
- i_wa_ld_data  in  4  load unit write-data nibble for the current phase.
- o_wa_ld_gnt  out  1  load unit request accepted this cycle.
- o_wa_wen  out  1  register file write enable.
- o_wa_reg  out  4  register file write index.
- o_wa_nib  out  2  nibble index being written (0 = bits 3:0, 3 = bits 15:12).
- o_wa_data  out  4  register file write-data nibble.
- o_wa_busy  out  1  write in progress.

Function
REQ-002 The block SHALL arbitrate the single register-file write port between the execution unit (EX) and the load unit (LD); each write SHALL occupy four consecutive cycles, one nibble per cycle, least-significant nibble first.
REQ-003 State SHALL consist of: busy flag, 2b nibble counter, owner bit (0 = EX, 1 = LD), latched register index, and last-winner bit.
REQ-004 The arbitration point SHALL be any cycle where busy is 0 or the nibble counter equals 3.
REQ-005 At an arbitration point with exactly one vld high, the block SHALL assert that requester's gnt combinationally in the same cycle.
REQ-006 At an arbitration point with both vld high, the block SHALL grant the requester that is not the last winner (round-robin).
REQ-007 At most one gnt SHALL be high in any cycle; no gnt SHALL be asserted outside an arbitration point or when its vld is low.
REQ-008 On a grant edge, the block SHALL set busy to 1, counter to 0, owner and last-winner to the granted requester, and latch that requester's reg input.
REQ-009 While busy, the counter SHALL increment by 1 each cycle; on the counter=3 cycle with no new grant, busy SHALL clear at the next edge.
REQ-010 A grant at counter=3 SHALL start the next write in the immediately following cycle with counter 0 (no bubble; 4-cycle throughput per write).
REQ-011 The outputs SHALL be o_wa_wen = busy, o_wa_nib = counter, o_wa_reg = latched index, and o_wa_data = the owner's data input muxed combinationally (zero added latency).
REQ-012 When busy is 0, o_wa_data and o_wa_reg SHALL be 0, and o_wa_busy SHALL equal busy.
REQ-013 A requester SHALL hold vld and reg stable until granted; deasserting vld before a grant is legal and SHALL leave state unchanged.
REQ-014 After a grant, the owner SHALL drive nibble n on its data input in the cycle where o_wa_nib = n; the block does not check this.
REQ-015 The non-owner's data and reg inputs SHALL have no effect on any output.
REQ-016 Successive grants to the same requester SHALL be permitted when the other vld is low.

Reset
REQ-017 While i_wa_rst_n is low, the block SHALL drive busy = 0, counter = 0, owner = 0, latched reg = 0, and last-winner = LD, so that EX wins the first contended arbitration.
REQ-018 Reset asserted mid-write SHALL abort the write immediately: o_wa_wen falls asynchronously and the partial write is not completed after release.
REQ-019 In the first cycle after reset release, both gnt outputs SHALL follow the normal rules (idle arbitration point).

Verification
REQ-020 EX only: ex_vld=1, reg=5, data nibbles 1,2,3,4 -> ex_gnt high 1 cycle; next 4 cycles wen=1, reg=5, nib 0..3, data 1,2,3,4; then wen=0.
REQ-021 Contention after reset: both vld=1 -> EX granted first; LD is granted at counter=3 and its wen begins the next cycle with nib=0 and no idle cycle.
REQ-022 Persistent contention over 4 writes -> grant order EX, LD, EX, LD; wen stays 1 continuously for 16 cycles.
REQ-023 LD requests at counter=1 of an EX write -> ld_gnt stays 0 until the counter=3 cycle, then asserts for exactly 1 cycle.
REQ-024 Reset pulse at nib=2 of a write -> wen=0 immediately; after release, wen=0 until a new grant; a pending EX/LD contention resolves to EX.
REQ-025 Non-owner toggles its data and reg every cycle during a write -> o_wa_data and o_wa_reg are unaffected.
